// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for a MIPS-style core: decodes the EX instruction,
// registers MEM-stage controls/data, resolves branches and overflow traps.
module ex_mem_reg #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_instruction,
  input  logic [31:0] ex_pc4,
  input  logic [31:0] ex_alu_result,
  input  logic [2:0]  ex_alu_flags,
  input  logic [31:0] ex_store_data,
  input  logic        mem_stall,
  input  logic        flush,
  input  logic        exc_ack,
  output logic        mem_valid,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_write_reg,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        ovf_exception,
  output logic [31:0] epc
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  function automatic logic rtype_writes(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B: rtype_writes = 1'b1;
      default:      rtype_writes = 1'b0;
    endcase
  endfunction

  function automatic logic itype_writes(input logic [5:0] op);
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
      OP_LW:   itype_writes = 1'b1;
      default: itype_writes = 1'b0;
    endcase
  endfunction

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic        is_rtype_s;
  logic        writes_s;
  logic        taken_s;
  logic        ovf_op_s;
  logic        capture_s;
  logic        live_s;
  logic        trap_s;
  logic [4:0]  dest_s;
  logic [31:0] target_s;

  logic        mem_valid_r;
  logic        mem_reg_write_r;
  logic        mem_mem_read_r;
  logic        mem_mem_write_r;
  logic [31:0] mem_alu_result_r;
  logic [31:0] mem_store_data_r;
  logic [4:0]  mem_write_reg_r;
  logic        redirect_r;
  logic [31:0] redirect_pc_r;
  logic        ovf_exception_r;
  logic [31:0] epc_r;

  // Instruction decode, branch resolution and trap detection for the EX word.
  always_comb begin
    opcode_s   = ex_instruction[31:26];
    funct_s    = ex_instruction[5:0];
    is_rtype_s = (opcode_s == OP_RTYPE);
    if (is_rtype_s) begin
      writes_s = rtype_writes(funct_s);
      dest_s   = ex_instruction[15:11];
      ovf_op_s = (funct_s == FN_ADD) || (funct_s == FN_SUB);
    end else begin
      writes_s = itype_writes(opcode_s);
      dest_s   = ex_instruction[20:16];
      ovf_op_s = (opcode_s == OP_ADDI);
    end
    case (opcode_s)
      OP_BEQ:  taken_s = ex_alu_flags[2];
      OP_BNE:  taken_s = ~ex_alu_flags[2];
      default: taken_s = 1'b0;
    endcase
    target_s  = ex_pc4 + {{14{ex_instruction[15]}}, ex_instruction[15:0], 2'b00};
    // Flush forces a capture even under stall, but the captured slot is a bubble.
    capture_s = flush | ~mem_stall;
    live_s    = ex_valid & ~flush;
    trap_s    = capture_s & live_s & ovf_op_s & ex_alu_flags[0];
  end

  // Pipeline payload and fetch redirect; redirect is a one-cycle pulse per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_r      <= 1'b0;
      mem_reg_write_r  <= 1'b0;
      mem_mem_read_r   <= 1'b0;
      mem_mem_write_r  <= 1'b0;
      mem_alu_result_r <= 32'h0;
      mem_store_data_r <= 32'h0;
      mem_write_reg_r  <= 5'h0;
      redirect_r       <= 1'b0;
      redirect_pc_r    <= 32'h0;
    end else if (capture_s) begin
      mem_valid_r      <= live_s;
      mem_reg_write_r  <= live_s & writes_s & ~trap_s;
      mem_mem_read_r   <= live_s & (opcode_s == OP_LW) & ~trap_s;
      mem_mem_write_r  <= live_s & (opcode_s == OP_SW) & ~trap_s;
      mem_alu_result_r <= ex_alu_result;
      mem_store_data_r <= ex_store_data;
      mem_write_reg_r  <= dest_s;
      redirect_r       <= trap_s | (live_s & taken_s);
      if (trap_s) begin
        redirect_pc_r <= EXC_VECTOR;
      end else if (live_s & taken_s) begin
        redirect_pc_r <= target_s;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end else begin
      redirect_r <= 1'b0;
    end
  end

  // Sticky overflow state: the first trap owns epc until acknowledged; a trap beats ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_exception_r <= 1'b0;
      epc_r           <= 32'h0;
    end else if (trap_s) begin
      ovf_exception_r <= 1'b1;
      if (!ovf_exception_r || exc_ack) begin
        epc_r <= ex_pc4 - 32'd4;
      end else begin
        epc_r <= epc_r;
      end
    end else if (exc_ack) begin
      ovf_exception_r <= 1'b0;
    end else begin
      ovf_exception_r <= ovf_exception_r;
    end
  end

  assign mem_valid      = mem_valid_r;
  assign mem_reg_write  = mem_reg_write_r;
  assign mem_mem_read   = mem_mem_read_r;
  assign mem_mem_write  = mem_mem_write_r;
  assign mem_alu_result = mem_alu_result_r;
  assign mem_store_data = mem_store_data_r;
  assign mem_write_reg  = mem_write_reg_r;
  assign redirect       = redirect_r;
  assign redirect_pc    = redirect_pc_r;
  assign ovf_exception  = ovf_exception_r;
  assign epc            = epc_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios then random traffic
// against a behavioural reference model.
module tb_ex_mem_reg;

  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_instruction;
  logic [31:0] ex_pc4;
  logic [31:0] ex_alu_result;
  logic [2:0]  ex_alu_flags;
  logic [31:0] ex_store_data;
  logic        mem_stall;
  logic        flush;
  logic        exc_ack;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_write_reg;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ovf_exception;
  logic [31:0] epc;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid, m_rw, m_mr, m_mw, m_redir, m_ovf;
  logic [31:0] m_alu, m_sd, m_rpc, m_epc;
  logic [4:0]  m_wr;

  int ops[17]    = '{0, 0, 0, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 'h23, 'h2B, 2, 3};
  int functs[18] = '{0, 2, 3, 4, 6, 7, 8, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h18};

  ex_mem_reg #(.EXC_VECTOR(EXC)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_instruction(ex_instruction),
    .ex_pc4(ex_pc4), .ex_alu_result(ex_alu_result), .ex_alu_flags(ex_alu_flags),
    .ex_store_data(ex_store_data), .mem_stall(mem_stall), .flush(flush), .exc_ack(exc_ack),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_write_reg(mem_write_reg), .redirect(redirect),
    .redirect_pc(redirect_pc), .ovf_exception(ovf_exception), .epc(epc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rinstr(input int rd, input int fn);
    logic [31:0] w;
    w = 32'h0;
    w[25:21] = 5'd1;
    w[20:16] = 5'd2;
    w[15:11] = rd[4:0];
    w[5:0]   = fn[5:0];
    return w;
  endfunction

  function automatic logic [31:0] iinstr(input int op, input int rt, input logic [15:0] imm);
    logic [31:0] w;
    w = 32'h0;
    w[31:26] = op[5:0];
    w[25:21] = 5'd1;
    w[20:16] = rt[4:0];
    w[15:0]  = imm;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw, m_redir, m_ovf} = 6'b0;
    m_alu = 32'h0; m_sd = 32'h0; m_rpc = 32'h0; m_epc = 32'h0; m_wr = 5'h0;
  endtask

  // Next-state of the reference model from the spec's rules, given current inputs.
  task automatic model_step();
    int op, fn;
    bit cap, live, writes, ovfop, trap, taken;
    logic [31:0] tgt;
    op     = int'(ex_instruction[31:26]);
    fn     = int'(ex_instruction[5:0]);
    cap    = flush || !mem_stall;
    live   = ex_valid && !flush;
    writes = (op == 0) ? (fn inside {0, 2, 3, 4, 6, 7, ['h20:'h27], 'h2A, 'h2B})
                       : (op inside {[8:14], 'h23});
    ovfop  = (op == 0) ? (fn == 'h20 || fn == 'h22) : (op == 8);
    trap   = cap && live && ovfop && ex_alu_flags[0];
    taken  = (op == 4 && ex_alu_flags[2]) || (op == 5 && !ex_alu_flags[2]);
    tgt    = ex_pc4 + 32'(signed'(ex_instruction[15:0])) * 32'd4;
    if (cap) begin
      m_valid = live;
      m_rw    = live && writes && !trap;
      m_mr    = live && op == 'h23 && !trap;
      m_mw    = live && op == 'h2B && !trap;
      m_alu   = ex_alu_result;
      m_sd    = ex_store_data;
      m_wr    = (op == 0) ? ex_instruction[15:11] : ex_instruction[20:16];
      m_redir = trap || (live && taken);
      if (trap) m_rpc = EXC;
      else if (live && taken) m_rpc = tgt;
    end else begin
      m_redir = 1'b0;
    end
    if (trap) begin
      if (!m_ovf || exc_ack) m_epc = ex_pc4 - 32'd4;
      m_ovf = 1'b1;
    end else if (exc_ack) begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(mem_valid), 32'(m_valid));
    chk({tag, ".rw"}, 32'(mem_reg_write), 32'(m_rw));
    chk({tag, ".mr"}, 32'(mem_mem_read), 32'(m_mr));
    chk({tag, ".mw"}, 32'(mem_mem_write), 32'(m_mw));
    chk({tag, ".redir"}, 32'(redirect), 32'(m_redir));
    chk({tag, ".ovf"}, 32'(ovf_exception), 32'(m_ovf));
    chk({tag, ".epc"}, epc, m_epc);
    if (m_valid) begin
      chk({tag, ".alu"}, mem_alu_result, m_alu);
      chk({tag, ".sd"}, mem_store_data, m_sd);
    end
    if (m_rw) chk({tag, ".wr"}, 32'(mem_write_reg), 32'(m_wr));
    if (m_redir) chk({tag, ".rpc"}, redirect_pc, m_rpc);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic [31:0] alu, input logic [2:0] fl, input logic st,
                       input logic fs, input logic ack);
    ex_valid = v; ex_instruction = ins; ex_pc4 = pc4; ex_alu_result = alu;
    ex_alu_flags = fl; ex_store_data = alu ^ 32'hA5A5_0000;
    mem_stall = st; flush = fs; exc_ack = ack;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, rinstr(3, 'h20), 32'h40, 32'h77, 3'b000, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // add rd=3 -> writes r3, no redirect
    drive(1'b1, rinstr(3, 'h20), 32'h40, 32'h5, 3'b000, 1'b0, 1'b0, 1'b0);
    tick("add");
    chk("add.wr3", 32'(mem_write_reg), 32'd3);
    chk("add.res", mem_alu_result, 32'h5);

    // beq taken backwards, then bubble, then not-taken
    drive(1'b1, iinstr(4, 5, 16'hFFFE), 32'h100, 32'h0, 3'b100, 1'b0, 1'b0, 1'b0);
    tick("beq_t");
    chk("beq_t.pc", redirect_pc, 32'hF8);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    tick("bubble");
    drive(1'b1, iinstr(4, 5, 16'hFFFE), 32'h100, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    tick("beq_nt");

    // addi overflow trap, then a second trap before ack
    drive(1'b1, iinstr(8, 7, 16'h0001), 32'h204, 32'h9, 3'b001, 1'b0, 1'b0, 1'b0);
    tick("addi_trap");
    chk("trap.epc", epc, 32'h200);
    chk("trap.rpc", redirect_pc, EXC);
    drive(1'b1, rinstr(4, 'h20), 32'h304, 32'h9, 3'b001, 1'b0, 1'b0, 1'b0);
    tick("trap2");
    chk("trap2.epc", epc, 32'h200);

    // ack clears; addu overflow never traps
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    tick("ack");
    drive(1'b1, rinstr(6, 'h21), 32'h400, 32'h1234, 3'b001, 1'b0, 1'b0, 1'b0);
    tick("addu");

    // taken bne then 3 stalled cycles with changing inputs
    drive(1'b1, iinstr(5, 1, 16'h0010), 32'h500, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    tick("bne_t");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, iinstr('h23, 9, 16'h0), 32'h600 + 32'(i), 32'hBEEF, 3'b001, 1'b1, 1'b0, 1'b0);
      tick("stall");
    end
    drive(1'b1, iinstr('h23, 9, 16'h0), 32'h700, 32'hCAFE, 3'b000, 1'b1, 1'b1, 1'b0);
    tick("flush_stall");

    // trap, then trap coinciding with ack: trap wins and epc updates
    drive(1'b1, rinstr(2, 'h22), 32'h804, 32'h1, 3'b001, 1'b0, 1'b0, 1'b0);
    tick("sub_trap");
    drive(1'b1, iinstr(8, 2, 16'h0), 32'h904, 32'h1, 3'b001, 1'b0, 1'b0, 1'b1);
    tick("trap_ack");
    chk("trap_ack.epc", epc, 32'h900);

    // async reset mid-stall: outputs drop before any edge
    drive(1'b1, iinstr('h2B, 3, 16'h0), 32'hA00, 32'h55, 3'b000, 1'b1, 1'b0, 1'b0);
    tick("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #3;
    rst_n = 1'b1;
    drive(1'b1, iinstr('h2B, 3, 16'h0), 32'hA00, 32'h55, 3'b000, 1'b0, 1'b0, 1'b0);
    tick("first_cap");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int op, fn;
      logic [31:0] ins;
      op  = ops[$urandom_range(0, 16)];
      fn  = functs[$urandom_range(0, 17)];
      ins = $urandom;
      ins[31:26] = op[5:0];
      ins[5:0]   = fn[5:0];
      drive($urandom_range(0, 7) != 0, ins, $urandom, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      ex_store_data = $urandom;
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h8000_0180: overflow exception handler address.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid, input, 1: EX stage holds a real instruction.
REQ-005 SHALL have port ex_instruction, input, 32: MIPS instruction word in EX.
REQ-006 SHALL have port ex_pc4, input, 32: address of that instruction plus 4.
REQ-007 SHALL have port ex_alu_result, input, 32: ALU result.
REQ-008 SHALL have port ex_alu_flags, input, 3: ALU flags; bit2 zero, bit1 negative, bit0 overflow.
REQ-009 SHALL have port ex_store_data, input, 32: rt operand for sw.
REQ-010 SHALL have ports mem_stall, flush and exc_ack, input, 1 each: hold register; squash capture; clear exception.
REQ-011 SHALL have ports mem_valid, mem_reg_write, mem_mem_read and mem_mem_write, output, 1 each.
REQ-012 SHALL have ports mem_alu_result and mem_store_data, output, 32, plus mem_write_reg, output, 5.
REQ-013 SHALL have ports redirect, output, 1, and redirect_pc, output, 32: fetch redirect for a taken branch or trap.
REQ-014 SHALL have ports ovf_exception, output, 1, sticky, and epc, output, 32.

Function
REQ-015 SHALL decode opcode [31:26] and funct [5:0]. R-type (opcode 0) SHALL write rd [15:11]; all other writing ops SHALL write rt [20:16].
REQ-016 SHALL set reg_write for these ops: R-type funct 00,02,03,04,06,07,20-27,2A,2B; opcodes 08-0E; lw (23). All other ops SHALL have reg_write 0.
REQ-017 SHALL set mem_read only for opcode 23 and mem_write only for opcode 2B.
REQ-018 SHALL treat beq (04) as taken when flags[2]=1 and bne (05) as taken when flags[2]=0.
REQ-019 SHALL compute the branch target as ex_pc4 + (sign-extended imm[15:0] << 2), using modulo-2^32 arithmetic.
REQ-020 SHALL detect an overflow trap on add (funct 20), sub (funct 22) or addi (opcode 08) when flags[0]=1. Unsigned ops SHALL never trap.
REQ-021 SHALL capture on a rising edge when mem_stall=0. A capture SHALL register all outputs.
REQ-022 SHALL make the captured instruction visible one cycle after it is presented (latency 1).
REQ-023 SHALL capture a bubble when ex_valid=0: mem_valid=0 and every control output 0. Data outputs are don't-care for a bubble.
REQ-024 SHALL hold all registered outputs while mem_stall=1.
REQ-025 SHALL assert redirect for exactly one cycle, on the capture of a taken branch or a trap. redirect SHALL NOT reassert while stalled.
REQ-026 On a taken branch, redirect_pc SHALL equal the branch target.
REQ-027 On a trap, redirect_pc SHALL equal EXC_VECTOR.
REQ-028 A trapping instruction SHALL be captured with mem_valid=1, mem_reg_write=0, mem_mem_read=0 and mem_mem_write=0.
REQ-029 A trap SHALL set ovf_exception=1 and epc=ex_pc4-4.
REQ-030 While ovf_exception=1, a further trap SHALL NOT overwrite epc, but SHALL still redirect.
REQ-031 exc_ack=1 SHALL clear ovf_exception on the next edge. When exc_ack and a new trap occur on the same edge, the trap SHALL win: ovf_exception stays 1 and epc is updated.
REQ-032 flush=1 SHALL capture a bubble on the next edge regardless of mem_stall (flush overrides stall), and SHALL suppress redirect and trap for that instruction.
REQ-033 Branches and bubbles SHALL capture with mem_reg_write=0.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for a clock, force mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, redirect and ovf_exception to 0.
REQ-035 rst_n=0 SHALL also force mem_alu_result, mem_store_data, redirect_pc and epc to 32'h0, and mem_write_reg to 5'h0.
REQ-036 Reset asserted mid-stall or mid-redirect SHALL discard the pending state.
REQ-037 The first capture SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-038 add with rd=3, result 32'h5, flags 000 -> next cycle: mem_valid=1, mem_reg_write=1, mem_write_reg=3, mem_alu_result=5, redirect=0.
REQ-039 beq, flags 100, ex_pc4=32'h100, imm=16'hFFFE -> redirect=1 for 1 cycle, redirect_pc=32'hF8, mem_reg_write=0. Same instruction with flags 000 -> redirect=0.
REQ-040 addi, flags 001, ex_pc4=32'h204 -> ovf_exception=1, epc=32'h200, redirect_pc=32'h8000_0180, mem_reg_write=0.
REQ-041 Second trap at ex_pc4=32'h304 before exc_ack -> epc stays 32'h200.
REQ-042 exc_ack pulse -> ovf_exception=0. addu with flags 001 -> no trap.
REQ-043 Stall for 3 cycles with a taken branch captured -> outputs held, redirect high 1 cycle only. flush with stall -> bubble next edge. rst_n low mid-cycle -> outputs 0 before next edge.
